// File: rtl/mem_dump_tx.sv
// Streams a run of 32-bit memory words out of a UART (8N1) line, MSB byte first.
// Words are fetched one at a time through a combinational read port.
module mem_dump_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  start_adr,
  input  logic [7:0]  word_count,
  output logic [7:0]  rd_adr,
  input  logic [31:0] rd_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStart,
    StData,
    StStop
  } state_e;

  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic [31:0]       word_q;
  logic [7:0]        byte_q;
  logic [1:0]        byte_idx_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        remaining_q;
  logic              tick;

  assign tick = (timer_q == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      word_q      <= '0;
      byte_q      <= '0;
      byte_idx_q  <= '0;
      bit_idx_q   <= '0;
      remaining_q <= '0;
      rd_adr      <= '0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (start) begin
            if (word_count == 8'd0) begin
              done <= 1'b1;
            end else begin
              state_q     <= StFetch;
              rd_adr      <= start_adr;
              remaining_q <= word_count;
              busy        <= 1'b1;
            end
          end
        end
        StFetch: begin
          // Top byte goes straight to the byte shifter; the rest waits in word_q.
          byte_q     <= rd_data[31:24];
          word_q     <= rd_data << 8;
          byte_idx_q <= '0;
          timer_q    <= TimerLoad;
          tx         <= 1'b0;
          state_q    <= StStart;
        end
        StStart: begin
          if (tick) begin
            timer_q   <= TimerLoad;
            bit_idx_q <= '0;
            tx        <= byte_q[0];
            byte_q    <= byte_q >> 1;
            state_q   <= StData;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        StData: begin
          if (tick) begin
            timer_q <= TimerLoad;
            if (bit_idx_q == 3'd7) begin
              tx      <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx        <= byte_q[0];
              byte_q    <= byte_q >> 1;
            end
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        StStop: begin
          if (tick) begin
            if (byte_idx_q != 2'd3) begin
              byte_idx_q <= byte_idx_q + 2'd1;
              byte_q     <= word_q[31:24];
              word_q     <= word_q << 8;
              timer_q    <= TimerLoad;
              tx         <= 1'b0;
              state_q    <= StStart;
            end else if (remaining_q > 8'd1) begin
              // tx stays high through the fetch cycle, stretching this stop bit.
              remaining_q <= remaining_q - 8'd1;
              rd_adr      <= rd_adr + 8'd1;
              state_q     <= StFetch;
            end else begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx with CLKS_PER_BIT=4: an independent UART
// receiver decodes tx while the stimulus checks timing, addresses and reset.
module tb_mem_dump_tx;

  localparam int unsigned Cpb = 4;
  localparam int WordCycles = 161;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_adr = 8'h00;
  logic [7:0]  word_count = 8'h00;
  logic [7:0]  rd_adr;
  logic [31:0] rd_data;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] mem [256];
  assign rd_data = mem[rd_adr];

  mem_dump_tx #(.CLKS_PER_BIT(Cpb)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .start_adr (start_adr),
    .word_count(word_count),
    .rd_adr    (rd_adr),
    .rd_data   (rd_data),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line monitor: UART receiver, done stamps, address trace, segment lengths.
  logic [7:0] rx_q[$];
  int         done_q[$];
  logic [7:0] adr_q[$];
  int         rx_st = 0;
  int         rx_off = 0;
  logic [7:0] rx_sh = 8'h00;
  logic       busy_prev = 1'b0;
  logic       tx_prev = 1'b1;
  int         run = 0;
  bit         run_busy = 1'b0;
  int         busy_cycles = 0;
  int         low_cycles = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      rx_st     = 0;
      busy_prev = 1'b0;
      tx_prev   = 1'b1;
      run       = 0;
      run_busy  = 1'b0;
    end else begin
      if (done) done_q.push_back(cyc);
      if (busy) busy_cycles++;
      if (!tx) low_cycles++;
      if (busy && (!busy_prev || adr_q.size() == 0 || adr_q[$] != rd_adr))
        adr_q.push_back(rd_adr);
      if (busy_prev && !busy && run_busy) begin
        check("seg_end", run % Cpb, 0);
        run_busy = 1'b0;
      end
      if (tx == tx_prev) begin
        run++;
      end else begin
        if (run_busy) begin
          if (!tx_prev) check("seg_low", run % Cpb, 0);
          else check("seg_high", ((run % Cpb) <= 1), 1);
        end
        run      = 1;
        run_busy = busy;
      end
      tx_prev = tx;
      if (rx_st == 0) begin
        if (!tx) begin
          rx_st  = 1;
          rx_off = 0;
        end
      end else begin
        rx_off++;
        if (rx_off == 3) check("start_bit", tx, 0);
        if (rx_off >= 6 && rx_off <= 34 && ((rx_off - 6) % 4) == 0) rx_sh = {tx, rx_sh[7:1]};
        if (rx_off == 38) begin
          check("stop_bit", tx, 1);
          rx_q.push_back(rx_sh);
        end
        if (rx_off == 39) rx_st = 0;
      end
      busy_prev = busy;
    end
  end

  // Returns the cycle index of the FETCH cycle (first cycle after acceptance).
  task automatic pulse_start(input logic [7:0] adr, input logic [7:0] cnt, output int e0);
    @(posedge clk); #1;
    start      = 1'b1;
    start_adr  = adr;
    word_count = cnt;
    @(posedge clk); #1;
    e0         = cyc;
    start      = 1'b0;
    start_adr  = 8'h77;
    word_count = 8'h55;
  endtask

  task automatic wait_done(input int n0, input int maxc, input string tag);
    int i = 0;
    while (done_q.size() <= n0 && i < maxc) begin
      @(negedge clk); #1;
      i++;
    end
    check({tag, "_timeout"}, done_q.size() > n0, 1);
  endtask

  task automatic check_word(input string tag, input int idx, input logic [31:0] w);
    logic [31:0] got;
    for (int b = 0; b < 4; b++) begin
      got = (idx + b < rx_q.size()) ? {24'h0, rx_q[idx + b]} : 32'hxxxxxxxx;
      check(tag, got, (w >> (24 - 8 * b)) & 32'hFF);
    end
  endtask

  task automatic check_done_time(input string tag, input int nd, input int e0, input int len);
    check(tag, (done_q.size() > nd) ? done_q[nd] - e0 : -1, len);
  endtask

  task automatic check_adr(input string tag, input int idx, input logic [7:0] exp);
    check(tag, (idx < adr_q.size()) ? {24'h0, adr_q[idx]} : 32'hxxxxxxxx, {24'h0, exp});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got no summary expected summary");
    $fatal(1);
  end

  initial begin
    int e0, nb, nd, na, bc, lc;
    for (int i = 0; i < 256; i++) mem[i] = (32'h0101_0101 * i) ^ 32'h5A3C_9612;
    mem[8'h05] = 32'hA5C3_0F81;
    mem[8'hFE] = 32'h1122_3344;
    mem[8'hFF] = 32'h5566_7788;
    mem[8'h00] = 32'h99AA_BBCC;
    mem[8'h20] = 32'hDEAD_BEEF;
    mem[8'h21] = 32'h0123_4567;
    mem[8'h09] = 32'hFFFF_FFFF;
    mem[8'h40] = 32'hF7E6_D5C4;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_adr", rd_adr, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single word
    nb = rx_q.size(); nd = done_q.size(); na = adr_q.size();
    pulse_start(8'h05, 8'd1, e0);
    @(negedge clk); #1;
    check("fetch_busy", busy, 1);
    check("fetch_tx", tx, 1);
    check("fetch_adr", rd_adr, 8'h05);
    @(negedge clk); #1;
    check("latency_tx_low", tx, 0);
    wait_done(nd, 400, "single");
    check_done_time("single_done_time", nd, e0, WordCycles);
    check("single_busy_at_done", busy, 0);
    check("single_tx_at_done", tx, 1);
    @(negedge clk); #1;
    check("single_done_pulse", done, 0);
    check("single_nbytes", rx_q.size() - nb, 4);
    check_word("single_byte", nb, 32'hA5C3_0F81);
    check("single_nadr", adr_q.size() - na, 1);
    check_adr("single_adr", na, 8'h05);

    // Multi-word with address wrap
    nb = rx_q.size(); nd = done_q.size(); na = adr_q.size();
    pulse_start(8'hFE, 8'd3, e0);
    wait_done(nd, 1000, "wrap");
    check_done_time("wrap_done_time", nd, e0, 3 * WordCycles);
    check("wrap_nbytes", rx_q.size() - nb, 12);
    check_word("wrap_w0", nb, 32'h1122_3344);
    check_word("wrap_w1", nb + 4, 32'h5566_7788);
    check_word("wrap_w2", nb + 8, 32'h99AA_BBCC);
    check("wrap_nadr", adr_q.size() - na, 3);
    check_adr("wrap_adr0", na, 8'hFE);
    check_adr("wrap_adr1", na + 1, 8'hFF);
    check_adr("wrap_adr2", na + 2, 8'h00);

    // Zero count
    nd = done_q.size(); bc = busy_cycles; lc = low_cycles;
    pulse_start(8'h33, 8'd0, e0);
    @(negedge clk); #1;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_tx", tx, 1);
    @(negedge clk); #1;
    check("zero_done_pulse", done, 0);
    repeat (5) @(negedge clk);
    #1;
    check("zero_busy_never", busy_cycles - bc, 0);
    check("zero_tx_never_low", low_cycles - lc, 0);
    check("zero_ndone", done_q.size() - nd, 1);

    // Start while busy is ignored
    nb = rx_q.size(); nd = done_q.size(); na = adr_q.size();
    pulse_start(8'h20, 8'd2, e0);
    repeat (50) @(posedge clk);
    #1;
    start = 1'b1; start_adr = 8'h09; word_count = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(nd, 1000, "busy_start");
    check_done_time("busy_done_time", nd, e0, 2 * WordCycles);
    check("busy_nbytes", rx_q.size() - nb, 8);
    check_word("busy_w0", nb, 32'hDEAD_BEEF);
    check_word("busy_w1", nb + 4, 32'h0123_4567);
    check("busy_nadr", adr_q.size() - na, 2);
    check_adr("busy_adr0", na, 8'h20);
    check_adr("busy_adr1", na + 1, 8'h21);
    repeat (200) @(negedge clk);
    #1;
    check("busy_no_queue", done_q.size() - nd, 1);
    check("busy_idle_after", busy, 0);

    // Reset during DATA bit 3 of the first byte (0xF7, bit3 = 0)
    nd = done_q.size();
    pulse_start(8'h40, 8'd1, e0);
    while (cyc < e0 + 18) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    check("abort_pre_bit3", tx, 0);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_adr", rd_adr, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("abort_no_done", done_q.size() - nd, 0);
    nb = rx_q.size(); nd = done_q.size();
    pulse_start(8'h40, 8'd1, e0);
    wait_done(nd, 400, "redo");
    check_done_time("redo_done_time", nd, e0, WordCycles);
    check("redo_nbytes", rx_q.size() - nb, 4);
    check_word("redo_byte", nb, 32'hF7E6_D5C4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dump_tx.md
MEM_DUMP_TX -- requirements
Module: mem_dump_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868; clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  reset, synchronous, active-low; sampled only on posedge clk.
REQ-004 start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
REQ-005 start_adr  input  8  first 32-bit word index; same encoding as memory check port (bit0 = low half, bits7:1 = 64-bit row).
REQ-006 word_count  input  8  number of 32-bit words to send; 0 is legal.
REQ-007 rd_adr  output  8  word index presented to memory combinational read port.
REQ-008 rd_data  input  32  word returned combinationally by memory for rd_adr, valid the same cycle.
REQ-009 tx  output  1  UART serial line, 8N1, idle high, registered.
REQ-010 busy  output  1  high from the cycle after start is accepted until the final stop bit completes.
REQ-011 done  output  1  one-cycle pulse when a dump completes.

Function
REQ-012 States: IDLE, FETCH, START, DATA, STOP; no other states reachable.
REQ-013 IDLE: tx=1, busy=0; start=1 with word_count!=0 -> FETCH, rd_adr<=start_adr, remaining<=word_count.
REQ-014 IDLE with start=1 and word_count=0 -> stay IDLE, done=1 next cycle, tx stays high, busy stays 0.
REQ-015 FETCH (exactly 1 cycle): latch rd_data into 32-bit shift word, byte index<=0 -> START.
REQ-016 Bytes of a word sent MSB byte first (rd_data[31:24], [23:16], [15:8], [7:0]); bits within a byte LSB first.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles -> DATA.
REQ-018 DATA: 8 bits, each held on tx for CLKS_PER_BIT cycles -> STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles; then byte index<3 -> START with next byte; byte index=3 and remaining>1 -> FETCH with rd_adr+1, remaining-1; byte index=3 and remaining=1 -> IDLE with done=1 for one cycle.
REQ-020 rd_adr increments modulo 256 (255 -> 0); no error on wrap.
REQ-021 Latency: start sampled at edge E0 -> FETCH during cycle after E0 -> tx first low in the cycle after that (2 cycles after E0).
REQ-022 Inter-word gap: stop bit extended by exactly one FETCH cycle (tx high); no gap between bytes of one word.
REQ-023 Bit timer counts CLKS_PER_BIT-1 down to 0; state/bit advance on terminal count; counter width = clog2(CLKS_PER_BIT).
REQ-024 start asserted while busy=1 is ignored; no queuing.
REQ-025 start_adr and word_count are only sampled on acceptance; later changes have no effect on an active dump.
REQ-026 Total dump duration for N>0 words: N*(4*10*CLKS_PER_BIT + 1) cycles from first FETCH to done.

Reset
REQ-027 reset_n=0 at a posedge -> next state IDLE, tx=1, busy=0, done=0, rd_adr=0, all counters 0.
REQ-028 Reset mid-operation (any state) aborts immediately; tx returns high on the following cycle; no done pulse.
REQ-029 reset_n has priority over start in the same cycle.

Verification (CLKS_PER_BIT=4)
REQ-030 Single word: memory[5]=32'hA5C3_0F81, start_adr=5, word_count=1 -> tx bytes A5,C3,0F,81 decoded 8N1; done 161 cycles after FETCH entry; rd_adr=5.
REQ-031 Multi-word wrap: start_adr=8'hFE, word_count=3 -> rd_adr sequence FE,FF,00; 12 bytes sent; one extra high cycle between words.
REQ-032 Zero count: start=1, word_count=0 -> done pulse next cycle, tx constant 1, busy never high.
REQ-033 Start while busy: second start with start_adr=9 mid-dump -> ignored; rd_adr never 9; only original words sent.
REQ-034 Reset mid-byte: reset_n=0 during DATA bit 3 -> next cycle tx=1, busy=0, done=0; new start afterwards yields a clean full dump.
REQ-035 Bit timing: every tx level segment is a multiple of 4 cycles except the 1-cycle FETCH extension; start bit exactly 4 cycles low.
